nibble_serial_add_ctrl: RTL and testbench

//  Multi-cycle sequencer that performs a WIDTH-bit addition on a single external
//  4-bit ripple adder, one nibble per clock, LSB nibble first.

---
 rtl/nibble_serial_add_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : Multi-cycle sequencer that performs a WIDTH-bit addition on
//                one shared external 4-bit adder. It sends one nibble per
//                clock, least-significant nibble first. The carry between
//                nibbles is held in a register.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     operand/result width in bits (multiple of 4, >= 4)
//  Optional feature
//    SERIAL_SUB_EN  when defined, adds input `sub`. If sub=1 at start, the
//                   block computes A-B in two's complement (cout=1: no borrow).
//  Ports
//    clk       in   rising-edge clock
//    rst_n     in   synchronous reset, active low
//    start     in   request, sampled only while idle
//    op_a      in   [WIDTH] operand A, latched on accepted start
//    op_b      in   [WIDTH] operand B, latched on accepted start
//    cin       in   carry-in, latched on accepted start
//    sub       in   subtract select (only with SERIAL_SUB_EN)
//    busy      out  high while nibbles are being processed
//    done      out  one-cycle pulse, result/cout valid
//    result    out  [WIDTH] sum, held until next accepted start
//    cout      out  final carry, held with result
//    add_a     out  [4] adder operand a
//    add_b     out  [4] adder operand b
//    add_cin   out  adder carry-in
//    add_sum   in   [4] adder sum (combinational return)
//    add_cout  in   adder carry-out
// ============================================================================
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int c_NIB  = WIDTH / 4;
  localparam int c_IDXW = (c_NIB > 1) ? $clog2(c_NIB) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NIB - 1);

  typedef enum logic [1:0] {
    c_IDLE = 2'd0,
    c_RUN  = 2'd1,
    c_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [c_IDXW-1:0]  r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;

  // --------------------------------------------------------------------------
  // Operand B and the initial carry as they are loaded at start. In subtract
  // mode, B is inverted and the carry is forced to 1. This gives A + ~B + 1 = A - B.
  // --------------------------------------------------------------------------
`ifdef SERIAL_SUB_EN
  assign w_b_load = sub ? ~op_b : op_b;
  assign w_c_load = sub ? 1'b1  : cin;
`else
  assign w_b_load = op_b;
  assign w_c_load = cin;
`endif

  assign w_accept = (r_state == c_IDLE) && start;
  assign w_last   = (r_idx == c_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. The adder ports are zero outside RUN, so
  // the shared adder sees no activity from this block while it is idle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    add_a       = 4'd0;
    add_b       = 4'd0;
    add_cin     = 1'b0;

    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = c_RUN;
        end
      end
      c_RUN: begin
        busy    = 1'b1;
        add_a   = r_a[r_idx*4 +: 4];
        add_b   = r_b[r_idx*4 +: 4];
        add_cin = r_carry;
        if (w_last) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE: begin
        done        = 1'b1;
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: load the operands on an accepted start. In each RUN cycle,
  // capture one sum nibble and the carry for the next nibble. The carry out
  // of the last nibble becomes the final cout.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= w_b_load;
      r_carry  <= w_c_load;
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == c_RUN) begin
      r_result[r_idx*4 +: 4] <= add_sum;
      r_carry                <= add_cout;
      r_idx                  <= r_idx + c_IDXW'(1);
      if (w_last) begin
        r_cout <= add_cout;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_add_ctrl
//  Description : Self-checking bench for nibble_serial_add_ctrl. It runs
//                directed and random operations. A behavioural model of the
//                external 4-bit adder is connected to the DUT. The bench
//                predicts results with whole-word arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
`ifdef SERIAL_SUB_EN
  localparam bit SUBEN = 1'b1;
`else
  localparam bit SUBEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef SERIAL_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External 4-bit ripple adder (combinational)
  logic [4:0] adder_full;
  always_comb begin
    adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    add_sum    = adder_full[3:0];
    add_cout   = adder_full[4];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Executes one operation. Checks every RUN cycle, the DONE cycle, and the
  // cycle after it. If poke=1, start is re-pulsed with other operands in the
  // second RUN cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s, input bit poke);
    longint unsigned mask_w, eb, ec, full, m, cin_k;
    mask_w = (64'd1 << WIDTH) - 1;
    eb     = (SUBEN && s) ? (~longint'(b)) & mask_w : longint'(b);
    ec     = (SUBEN && s) ? 64'd1 : longint'(c);
    full   = longint'(a) + eb + ec;

    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    @(negedge clk);
    for (int k = 0; k < NIB; k++) begin
      start = (poke && k == 1);
      op_a  = WIDTH'($urandom);
      op_b  = WIDTH'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      m     = (64'd1 << (4*k)) - 1;
      cin_k = ((longint'(a) & m) + (eb & m) + ec) >> (4*k);
      chk($sformatf("run%0d_busy", k), 64'(busy), 64'd1);
      chk($sformatf("run%0d_done", k), 64'(done), 64'd0);
      chk($sformatf("run%0d_add_a", k), 64'(add_a), (longint'(a) >> (4*k)) & 64'hF);
      chk($sformatf("run%0d_add_b", k), 64'(add_b), (eb >> (4*k)) & 64'hF);
      chk($sformatf("run%0d_add_cin", k), 64'(add_cin), cin_k & 64'd1);
      chk($sformatf("run%0d_partial", k), 64'(result), full & m);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_result", 64'(result), full & mask_w);
    chk("done_cout", 64'(cout), (full >> WIDTH) & 64'd1);
    chk("done_add_idle", {59'd0, add_a, add_cin}, 64'd0);
    @(negedge clk);
    chk("post_done", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_result_held", 64'(result), full & mask_w);
    chk("post_cout_held", 64'(cout), (full >> WIDTH) & 64'd1);
    chk("post_add_b_idle", 64'(add_b), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_adder", {56'd0, add_a, add_b} | 64'(add_cin), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b1);  // start during RUN ignored
    if (SUBEN) begin
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    end

    // Reset in the 2nd RUN cycle discards the operation
    @(negedge clk);
    start = 1'b1; op_a = 16'h8888; op_b = 16'h8888; cin = 1'b1; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_add_a", 64'(add_a), 64'd0);
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_nodone%0d", i), 64'(done), 64'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
